// File: rtl/exp_pkg.sv
// Shared constants and types for the iterative shift-add exponential unit.
//   LN2_Q62 : ln(2) in unsigned Q2.62
//   LN_TBL  : LN_TBL[k] = ln(1 + 2^-k) in unsigned Q2.62, k = 1..30
//   state_t : controller states
package exp_pkg;

  localparam logic [63:0] LN2_Q62 = 64'h2C5C_85FD_F473_DE6A;

  typedef logic [30:1][63:0] ln_tbl_t;

  // ln(1 + 2^-k) via the alternating series sum((-1)^(n+1) * 2^(-n*k) / n),
  // accumulated in Q4.124 and truncated to Q2.62.
  function automatic logic [63:0] ln1p_pow2(input int unsigned k);
    logic [127:0] acc;
    logic [127:0] term;
    acc = '0;
    for (int unsigned n = 1; n * k <= 32'd124; n++) begin
      term = (128'(1) << (32'd124 - n * k)) / 128'(n);
      if (n[0]) acc = acc + term;
      else      acc = acc - term;
    end
    return 64'(acc >> 62);
  endfunction

  // Built from k = 30 down to 1 so entry k lands at packed index k.
  function automatic ln_tbl_t build_ln_tbl();
    ln_tbl_t t;
    t = '0;
    for (int unsigned k = 30; k >= 1; k--) t = {t[29:1], ln1p_pow2(k)};
    return t;
  endfunction

  localparam ln_tbl_t LN_TBL = build_ln_tbl();

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INT  = 2'd1,
    S_FRAC = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/exp_step.sv
// One combinational shift-add step, shared by both phases.
//   x, y     : current residual and result
//   c        : constant to subtract (ln2 or ln(1+2^-k))
//   sh       : shift k for the add-shift mode
//   dbl      : 1 = integer phase (y*2), 0 = fractional phase (y + y>>k)
//   x_step_c : x - c (candidate residual)
//   y_step_c : stepped y (candidate result)
//   take_c   : x >= c, step should be applied
module exp_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] c,
  input  logic [4:0]   sh,
  input  logic         dbl,
  output logic [W-1:0] x_step_c,
  output logic [W-1:0] y_step_c,
  output logic         take_c
);

  // Zero residual against an equal constant still takes the step.
  assign take_c   = (x >= c);
  assign x_step_c = x - c;
  assign y_step_c = dbl ? (y << 1) : (y + (y >> sh));

endmodule

// File: rtl/shift_add_exp_iter.sv
// Iterative fixed-point exp(x), unsigned Q(W-FRAC).FRAC, one step per clock:
// INT_STEPS ln2 subtractions (y doubles) then ITER ln(1+2^-k) subtractions
// (y += y>>k). Optional overflow saturation under macro EXP_OVF_EN.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : argument handshake, in_x argument
//   out_valid/out_ready : result handshake, out_y = exp(in_x)
//   out_resid           : final residual (error diagnostic)
//   busy                : controller not idle
//   ovf                 : overflow (tied 0 unless EXP_OVF_EN)
module shift_add_exp_iter
  import exp_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned FRAC      = 24,
  parameter int unsigned INT_STEPS = 6,
  parameter int unsigned ITER      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_resid,
  output logic         busy,
  output logic         ovf
);

  localparam int unsigned SH      = 62 - FRAC;
  localparam int unsigned CNT_MAX = (ITER > INT_STEPS) ? ITER : INT_STEPS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [W-1:0] LN2    = W'(LN2_Q62 >> SH);
  localparam logic [W-1:0] ONE    = W'(1) << FRAC;

  state_t             state, state_nxt;
  logic [W-1:0]       xr, yr, xr_nxt, yr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               out_valid_nxt, busy_nxt;
  logic [W-1:0]       out_y_nxt, out_resid_nxt;
  logic [W-1:0]       c_frac, c_sel, x_step, y_step, xr_adv, yr_adv;
  logic               take, dbl, last_int, last_frac;

`ifdef EXP_OVF_EN
  logic ovf_r, ovf_r_nxt, ovf_nxt;
`endif

  // Constant select for k = cnt as a priority chain over the table.
  for (genvar k = 1; k <= ITER; k++) begin : g_c
    localparam logic [W-1:0] CK = W'(LN_TBL[k] >> SH);
    logic [W-1:0] acc;
    if (k == 1) begin : g_first
      assign acc = (cnt == CNT_W'(k)) ? CK : '0;
    end else begin : g_rest
      assign acc = (cnt == CNT_W'(k)) ? CK : g_c[k-1].acc;
    end
  end
  assign c_frac = g_c[ITER].acc;

  assign dbl       = (state == S_INT);
  assign c_sel     = dbl ? LN2 : c_frac;
  assign last_int  = (cnt == CNT_W'(INT_STEPS - 1));
  assign last_frac = (cnt == CNT_W'(ITER));

  exp_step #(.W(W)) u_step (
    .x        (xr),
    .y        (yr),
    .c        (c_sel),
    .sh       (5'(cnt)),
    .dbl      (dbl),
    .x_step_c (x_step),
    .y_step_c (y_step),
    .take_c   (take)
  );

  assign xr_adv = take ? x_step : xr;
  assign yr_adv = take ? y_step : yr;

  // Next-state and datapath control.
  always_comb begin
    state_nxt     = state;
    xr_nxt        = xr;
    yr_nxt        = yr;
    cnt_nxt       = cnt;
    out_valid_nxt = out_valid;
    out_y_nxt     = out_y;
    out_resid_nxt = out_resid;
    in_ready      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          xr_nxt    = in_x;
          yr_nxt    = ONE;
          cnt_nxt   = '0;
          state_nxt = S_INT;
        end
      end
      S_INT: begin
        xr_nxt = xr_adv;
        yr_nxt = yr_adv;
        if (last_int) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = S_FRAC;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_FRAC: begin
        xr_nxt = xr_adv;
        yr_nxt = yr_adv;
        if (last_frac) begin
          state_nxt     = S_DONE;
          out_valid_nxt = 1'b1;
          out_resid_nxt = xr_adv;
`ifdef EXP_OVF_EN
          out_y_nxt     = ovf_r ? '1 : yr_adv;
`else
          out_y_nxt     = yr_adv;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          in_ready      = 1'b1;
          out_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
          // Back-to-back: accept the next argument in the handshake cycle.
          if (in_valid) begin
            xr_nxt    = in_x;
            yr_nxt    = ONE;
            cnt_nxt   = '0;
            state_nxt = S_INT;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      xr        <= '0;
      yr        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_resid <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      xr        <= xr_nxt;
      yr        <= yr_nxt;
      cnt       <= cnt_nxt;
      out_valid <= out_valid_nxt;
      out_y     <= out_y_nxt;
      out_resid <= out_resid_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef EXP_OVF_EN
  // Overflow: residual still >= ln2 once the integer phase is exhausted.
  always_comb begin
    ovf_r_nxt = ovf_r;
    ovf_nxt   = ovf;
    if (state == S_INT && last_int)    ovf_r_nxt = (xr_adv >= LN2);
    if (state == S_FRAC && last_frac)  ovf_nxt   = ovf_r;
    if (state == S_DONE && out_ready)  ovf_nxt   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf_r <= ovf_r_nxt;
      ovf   <= ovf_nxt;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_shift_add_exp_iter.sv
// Directed table-driven bench for shift_add_exp_iter (default parameters),
// plus hand-written back-pressure and mid-operation reset sequences.
module tb_shift_add_exp_iter;

  localparam logic [31:0] LN2      = 32'h00B1_7217;
  localparam logic [31:0] C_ITER   = 32'd255;   // floor(ln(1+2^-16) * 2^24)
  localparam int          LATENCY  = 22;
`ifdef EXP_OVF_EN
  localparam bit          OVF_ON   = 1'b1;
`else
  localparam bit          OVF_ON   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [31:0] out_resid;
  logic        busy;
  logic        ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  shift_add_exp_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_resid (out_resid),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] tol;
    logic        chk_y;
    logic        chk_r;
    logic        r_exact;   // 1: resid == r, 0: resid < r
    logic [31:0] r;
    logic        ovf;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] tol, input logic chk_y,
                              input logic chk_r, input logic r_exact,
                              input logic [31:0] r, input logic o);
    vec_t v;
    v.x = x; v.y = y; v.tol = tol; v.chk_y = chk_y;
    v.chk_r = chk_r; v.r_exact = r_exact; v.r = r; v.ovf = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input logic [31:0] tol);
    logic [31:0] d;
    d = (act > exp) ? act - exp : exp - act;
    tests_run++;
    if ($isunknown(act) || d > tol) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic chk_lt(input string name, input logic [31:0] act, input logic [31:0] bound);
    tests_run++;
    if ($isunknown(act) || act >= bound) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected below 0x%08h", name, act, bound);
    end
  endtask

  // Present x in IDLE and let the next edge accept it.
  task automatic accept(input logic [31:0] x);
    @(negedge clk);
    in_x     = x;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from just after the accept edge until out_valid rises.
  task automatic wait_done(output logic [31:0] y, output logic [31:0] r,
                           output logic o, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y = out_y;
    r = out_resid;
    o = ovf;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [9];
    logic [31:0] y, r, y0;
    logic        o;
    int          lat;

    vecs[0] = mk(32'h0000_0000, 32'h0100_0000, 32'd0,    1, 1, 1, 32'd0, 1'b0);
    vecs[1] = mk(LN2,           32'h0200_0000, 32'd1024, 1, 1, 1, 32'd0, 1'b0);
    vecs[2] = mk(LN2 + 32'd1,   32'h0200_0000, 32'd0,    1, 1, 1, 32'd1, 1'b0);
    vecs[3] = mk(LN2 - 32'd1,   32'h0200_0000, 32'd1024, 1, 1, 0, C_ITER, 1'b0);
    vecs[4] = mk(32'h0100_0000, 32'h02B7_E151, 32'd1024, 1, 1, 0, C_ITER, 1'b0);
    vecs[5] = mk(LN2 * 2,       32'h0400_0000, 32'd0,    1, 1, 1, 32'd0, 1'b0);
    vecs[6] = mk(LN2 * 6,       32'h4000_0000, 32'd0,    1, 1, 1, 32'd0, 1'b0);
    vecs[7] = mk(LN2 * 7,       32'hFFFF_FFFF, 32'd0,    OVF_ON, 0, 0, 32'd0, OVF_ON);
    vecs[8] = mk(32'h0500_0000, 32'hFFFF_FFFF, 32'd0,    OVF_ON, 0, 0, 32'd0, OVF_ON);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y",     out_y,          32'd0);
    chk("rst_out_resid", out_resid,      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].x);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_done(y, r, o, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LATENCY));
      if (vecs[i].chk_y) chk_tol($sformatf("v%0d_out_y", i), y, vecs[i].y, vecs[i].tol);
      if (vecs[i].chk_r) begin
        if (vecs[i].r_exact) chk($sformatf("v%0d_resid", i), r, vecs[i].r);
        else                 chk_lt($sformatf("v%0d_resid", i), r, vecs[i].r);
      end
      chk($sformatf("v%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
      release_result();
      chk($sformatf("v%0d_idle_after", i), 32'(busy), 32'd0);
    end

    // Back-pressure in DONE, then back-to-back accept on the handshake edge.
    accept(32'h0000_0000);
    wait_done(y0, r, o, lat);
    chk("bp_latency", 32'(lat), 32'(LATENCY));
    chk("bp_out_y",   y0,       32'h0100_0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", i),    32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_out_y", i),    out_y,          32'h0100_0000);
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = LN2;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_busy",      32'(busy),      32'd1);
    chk("b2b_out_valid", 32'(out_valid), 32'd0);
    wait_done(y, r, o, lat);
    chk("b2b_latency", 32'(lat), 32'(LATENCY));
    chk("b2b_out_y",   y,        32'h0200_0000);
    release_result();

    // Reset on the third fractional-phase cycle aborts the computation.
    accept(32'h0100_0000);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_y",     out_y,          32'd0);
    chk("mrst_busy",      32'(busy),      32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    accept(32'h0000_0000);
    wait_done(y, r, o, lat);
    chk("post_rst_latency", 32'(lat), 32'(LATENCY));
    chk("post_rst_out_y",   y,        32'h0100_0000);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_add_exp_iter.md
Name: shift_add_exp_iter

Overview:
- Iterative fixed-point exponential unit: y = exp(x) for unsigned x, computed by shift-add, one step per clock.
- Two phases:
  - Integer phase: ln2 subtraction with y doubling.
  - Fractional phase: ln(1+2^-k) subtraction with y += y>>k.
- Generalised, multi-cycle successor of the single-stage conditional shift-add cell.
- Valid/ready on both sides; sits between the argument-reduction front end and the result FIFO.

Parameters:
- W, 32, data width of x, y and residual.
- FRAC, 24, fractional bits (Q(W-FRAC).FRAC unsigned).
- INT_STEPS, 6, integer-phase cycles (ln2 subtractions); require W-FRAC >= INT_STEPS+2.
- ITER, 16, fractional-phase cycles, k = 1..ITER; range 1..30; require ITER <= FRAC.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  argument valid
- in_ready  out  1  argument accepted when in_valid&in_ready
- in_x  in  W  argument, Q(W-FRAC).FRAC
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_y  out  W  exp(in_x), same format
- out_resid  out  W  final residual x (error diagnostic)
- busy  out  1  state != IDLE
- ovf  out  1  overflow flag (see Optional Feature)

Behaviour:
- Reset: rst, synchronous, active-high. Clears state to IDLE; out_valid=0, out_y=0, out_resid=0, ovf=0, busy=0, counter=0. Reset mid-operation aborts; the in-flight result is discarded.
- FSM states: IDLE, INT, FRAC, DONE.
- IDLE: in_ready=1.
  - On accept: xr<=in_x, yr<=1.0 (1<<FRAC), cnt<=0, go to INT.
- INT, INT_STEPS cycles, fixed latency:
  - If xr >= LN2: xr<=xr-LN2, yr<=yr<<1.
  - Else: hold.
  - After the last INT cycle: cnt<=1, go to FRAC.
  - Overflow condition: xr >= LN2 at INT exit; latched into internal ovf_r.
- FRAC, ITER cycles, k=cnt:
  - If xr >= C[k]: xr<=xr-C[k], yr<=yr+(yr>>k).
  - Else: hold.
  - When cnt==ITER, after the update go to DONE.
- Comparison is >= (zero residual takes the step). All arithmetic is unsigned, W bits, truncating shifts. No rounding.
- DONE: out_valid=1; out_y/out_resid/ovf stable until handshake.
  - On out_ready: go to IDLE.
  - in_ready = IDLE | (DONE & out_ready). A new argument accepted in that same cycle goes straight to INT (back-to-back, no bubble).
- Latency: accept cycle + INT_STEPS + ITER cycles to out_valid (defaults: out_valid 22 cycles after accept edge).
- Constants:
  - LN2 = pkg LN2_Q62 >> (62-FRAC).
  - C[k] = pkg LN_TBL[k] >> (62-FRAC).
  - Truncated.
- in_valid while not in_ready is ignored; the argument must be held by the source.

Optional Feature:
- Macro EXP_OVF_EN.
- Defined:
  - ovf = ovf_r in DONE.
  - On overflow, out_y saturates to all-ones and out_resid to the computed residual.
- Undefined:
  - ovf tied 0; overflow logic absent.
  - out_y is the wrapped computed value; result undefined for x >= (INT_STEPS+1)·ln2.

Decomposition:
- Package exp_pkg:
  - LN2_Q62 (64-bit).
  - LN_TBL[1..30] = ln(1+2^-k) in Q2.62.
  - State enum {IDLE, INT, FRAC, DONE}.
- Sub-module exp_step: combinational.
  - Inputs: xr, yr, constant, shift amount, mode (double vs add-shift).
  - Outputs: next xr, yr, take flag.
  - Instantiated once, muxed by phase.

Test Plan:
- x=0x00000000 -> out_y=0x01000000, out_resid=0, ovf=0, out_valid exactly 22 cycles after accept.
- x=0x00B17217 (ln2) -> out_y=0x02000000 ±2^(FRAC-ITER+2) LSB; one INT step taken.
- x=0x01000000 (1.0) -> out_y≈0x02B7E151 within ±1024 LSB; out_resid < C[ITER].
- Back-pressure: out_ready=0 for 5 cycles in DONE -> out_y/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new argument accepted that cycle, busy stays 1.
- rst pulsed on FRAC cycle 3 -> next cycle IDLE, out_valid=0, out_y=0; a following x=0 gives 0x01000000.
- With EXP_OVF_EN, x=0x05000000 (5.0 > 6·ln2) -> ovf=1, out_y=0xFFFFFFFF. Without the macro, ovf=0.
